// File: rtl/fsmc_pkg.sv
// Purpose: shared constants for the FSMC register slave (state indices, sync depth, defaults).
// Latency: n/a (package only).
// Backpressure: n/a.
package fsmc_pkg;

  // One-hot state bit positions
  localparam int ST_IDLE  = 0;
  localparam int ST_WRITE = 1;
  localparam int ST_RWAIT = 2;
  localparam int ST_DRIVE = 3;
  localparam int ST_HOLD  = 4;
  localparam int NUM_ST   = 5;

  localparam int SYNC_STAGES = 2;
  localparam int CNT_W       = 4;

  localparam int DEF_ADRW   = 8;
  localparam int DEF_DATW   = 16;
  localparam int DEF_RD_LAT = 1;

  typedef logic [NUM_ST-1:0] state_t;

  // One-hot encoding for a given state index
  function automatic state_t st_oh(input int idx);
    state_t v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/synchroniser_rst.sv
// Purpose: W-bit multi-flop synchroniser whose flops reset to 1 (idle-high strobes).
// Latency: STAGES clk cycles from d_in to d_out.
// Backpressure: none; free-running.
// Ports: clk, nrst (async active-low), d_in[W] async input, d_out[W] synchronised output.
module synchroniser_rst #(
  parameter int W      = 3,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] d_out
);

  logic [STAGES-1:0][W-1:0] sync_q;
  logic [STAGES-1:0][W-1:0] sync_d;

  always_comb begin
    sync_d[0] = d_in;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign d_out = sync_q[STAGES-1];

endmodule

// File: rtl/fsmc_reg_slave.sv
// Purpose: FSMC async-SRAM bus slave; turns host strobes into one-cycle register read/write strobes.
// Latency: strobe 1 cycle after the synchronised qualifier (3 clk after the pin edge); read drive RD_LAT cycles after do_read.
// Backpressure: none to the host unless FSMC_NWAIT_EN is defined, which adds aNWAIT held low while read data is pending.
// Ports: clk/nrst; host pins aNE/aNOE/aNWE/aNBL/aA/aD_in/aD_out/aD_oe;
//        register side rw_adr/do_write/w_data/w_be/do_read/read_data; prot_err/err_clr;
//        aNWAIT only when FSMC_NWAIT_EN is defined.
module fsmc_reg_slave
  import fsmc_pkg::*;
#(
  parameter int ADRW   = DEF_ADRW,
  parameter int DATW   = DEF_DATW,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              aNE,
  input  logic              aNOE,
  input  logic              aNWE,
  input  logic [DATW/8-1:0] aNBL,
  input  logic [ADRW-1:0]   aA,
  input  logic [DATW-1:0]   aD_in,
  output logic [DATW-1:0]   aD_out,
  output logic              aD_oe,
  output logic [ADRW-1:0]   rw_adr,
  output logic              do_write,
  output logic [DATW-1:0]   w_data,
  output logic [DATW/8-1:0] w_be,
  output logic              do_read,
  input  logic [DATW-1:0]   read_data,
  output logic              prot_err,
  input  logic              err_clr
`ifdef FSMC_NWAIT_EN
  ,
  output logic              aNWAIT
`endif
);

  localparam int BEW = DATW / 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  localparam state_t S_IDLE  = st_oh(ST_IDLE);
  localparam state_t S_WRITE = st_oh(ST_WRITE);
  localparam state_t S_RWAIT = st_oh(ST_RWAIT);
  localparam state_t S_DRIVE = st_oh(ST_DRIVE);
  localparam state_t S_HOLD  = st_oh(ST_HOLD);

  // Synchronised control strobes
  logic s_ne, s_noe, s_nwe;

  synchroniser_rst #(
    .W      (3),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .nrst  (nrst),
    .d_in  ({aNE, aNOE, aNWE}),
    .d_out ({s_ne, s_noe, s_nwe})
  );

  // Qualifiers evaluated in IDLE; mutually exclusive by construction
  logic wr_c, rd_c, err_c;
  assign wr_c  = ~s_ne & ~s_nwe &  s_noe;
  assign rd_c  = ~s_ne & ~s_noe &  s_nwe;
  assign err_c = ~s_ne & ~s_noe & ~s_nwe;

  state_t            state_q, state_d;
  logic [ADRW-1:0]   rw_adr_q, rw_adr_d;
  logic [DATW-1:0]   w_data_q, w_data_d;
  logic [BEW-1:0]    w_be_q, w_be_d;
  logic              do_write_q, do_write_d;
  logic              do_read_q, do_read_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATW-1:0]   ad_out_q, ad_out_d;
  logic              prot_err_q, prot_err_d;

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (1'b1)
      state_q[ST_IDLE]: begin
        if (err_c)     state_d = S_HOLD;
        else if (wr_c) state_d = S_WRITE;
        else if (rd_c) state_d = S_RWAIT;
      end
      state_q[ST_WRITE]: if (s_ne | s_nwe) state_d = S_IDLE;
      // Host giving up mid-wait abandons the read; do_read has already fired
      state_q[ST_RWAIT]: begin
        if (s_ne | s_noe)      state_d = S_IDLE;
        else if (cnt_q == '0)  state_d = S_DRIVE;
      end
      state_q[ST_DRIVE]: if (s_ne | s_noe) state_d = S_IDLE;
      state_q[ST_HOLD]:  if (s_ne) state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    rw_adr_d   = rw_adr_q;
    w_data_d   = w_data_q;
    w_be_d     = w_be_q;
    do_write_d = 1'b0;
    do_read_d  = 1'b0;
    cnt_d      = cnt_q;
    ad_out_d   = ad_out_q;
    // A new error in the same cycle as err_clr keeps the flag set
    prot_err_d = err_clr ? 1'b0 : prot_err_q;

    if (state_q[ST_IDLE]) begin
      if (err_c) begin
        prot_err_d = 1'b1;
      end else if (wr_c) begin
        do_write_d = 1'b1;
        rw_adr_d   = aA;
        w_data_d   = aD_in;
        w_be_d     = ~aNBL;
      end else if (rd_c) begin
        do_read_d  = 1'b1;
        rw_adr_d   = aA;
        cnt_d      = CNT_LOAD;
      end
    end

    if (state_q[ST_RWAIT] && !(s_ne | s_noe)) begin
      if (cnt_q == '0) begin
        ad_out_d = read_data;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rw_adr_q   <= '0;
      w_data_q   <= '0;
      w_be_q     <= '0;
      do_write_q <= 1'b0;
      do_read_q  <= 1'b0;
      cnt_q      <= '0;
      ad_out_q   <= '0;
      prot_err_q <= 1'b0;
    end else begin
      rw_adr_q   <= rw_adr_d;
      w_data_q   <= w_data_d;
      w_be_q     <= w_be_d;
      do_write_q <= do_write_d;
      do_read_q  <= do_read_d;
      cnt_q      <= cnt_d;
      ad_out_q   <= ad_out_d;
      prot_err_q <= prot_err_d;
    end
  end

  assign rw_adr   = rw_adr_q;
  assign w_data   = w_data_q;
  assign w_be     = w_be_q;
  assign do_write = do_write_q;
  assign do_read  = do_read_q;
  assign aD_out   = ad_out_q;
  assign prot_err = prot_err_q;

  // Registered state gated by live strobes so the pad releases as soon as the host lets go
  assign aD_oe = state_q[ST_DRIVE] & ~s_ne & ~s_noe;

`ifdef FSMC_NWAIT_EN
  // Low for every cycle spent in RWAIT; releases on the edge that enters DRIVE
  logic nwait_q, nwait_d;

  always_comb begin
    nwait_d = ~state_d[ST_RWAIT];
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      nwait_q <= 1'b1;
    end else begin
      nwait_q <= nwait_d;
    end
  end

  assign aNWAIT = nwait_q;
`endif

endmodule

// File: tb/tb_fsmc_reg_slave.sv
// Purpose: directed bench for fsmc_reg_slave with a strobe/read-data scoreboard.
// Latency: checks write strobe 3 clk after pin edge and aD_oe RD_LAT clk after do_read.
// Backpressure: exercises aNWAIT when FSMC_NWAIT_EN is defined.
module tb_fsmc_reg_slave;

`ifdef FSMC_NWAIT_EN
  localparam int RD_LAT = 5;
`else
  localparam int RD_LAT = 8;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic        aNE, aNOE, aNWE;
  logic [1:0]  aNBL;
  logic [7:0]  aA;
  logic [15:0] aD_in;
  logic [15:0] aD_out;
  logic        aD_oe;
  logic [7:0]  rw_adr;
  logic        do_write;
  logic [15:0] w_data;
  logic [1:0]  w_be;
  logic        do_read;
  logic [15:0] read_data;
  logic        prot_err;
  logic        err_clr;
`ifdef FSMC_NWAIT_EN
  logic        aNWAIT;
`endif

  always #5 clk = ~clk;

  fsmc_reg_slave #(
    .ADRW   (8),
    .DATW   (16),
    .RD_LAT (RD_LAT)
  ) u_dut (
    .clk       (clk),
    .nrst      (nrst),
    .aNE       (aNE),
    .aNOE      (aNOE),
    .aNWE      (aNWE),
    .aNBL      (aNBL),
    .aA        (aA),
    .aD_in     (aD_in),
    .aD_out    (aD_out),
    .aD_oe     (aD_oe),
    .rw_adr    (rw_adr),
    .do_write  (do_write),
    .w_data    (w_data),
    .w_be      (w_be),
    .do_read   (do_read),
    .read_data (read_data),
    .prot_err  (prot_err),
    .err_clr   (err_clr)
`ifdef FSMC_NWAIT_EN
    ,
    .aNWAIT    (aNWAIT)
`endif
  );

  typedef struct {
    bit          is_wr;
    logic [7:0]  adr;
    logic [15:0] dat;
    logic [1:0]  be;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] rd_q[$];

  int n_asrt = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_wr = 0, n_rd = 0, n_oe = 0;
  int last_wr_cyc = 0, last_rd_cyc = 0, oe_rise_cyc = 0;
  int nwait_low = 0;
  logic oe_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: pops expected strobes and read data as the DUT produces them
  initial forever begin
    @(posedge clk);
    #1;
    if (do_write || do_read) begin
      exp_t e;
      check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("strobe_kind", {31'b0, do_write}, {31'b0, e.is_wr});
        check("rw_adr", {24'b0, rw_adr}, {24'b0, e.adr});
        if (do_write) begin
          check("w_data", {16'b0, w_data}, {16'b0, e.dat});
          check("w_be", {30'b0, w_be}, {30'b0, e.be});
        end
      end
      if (do_write) begin
        n_wr++;
        last_wr_cyc = cyc;
      end else begin
        n_rd++;
        last_rd_cyc = cyc;
      end
    end
    if (aD_oe && !oe_prev) begin
      n_oe++;
      oe_rise_cyc = cyc;
      check("rd_expected", 32'(rd_q.size() != 0), 32'd1);
      if (rd_q.size() != 0) check("aD_out", {16'b0, aD_out}, {16'b0, rd_q.pop_front()});
    end
    oe_prev = aD_oe;
`ifdef FSMC_NWAIT_EN
    if (!aNWAIT) nwait_low++;
`endif
  end

  // Sample point sits after the monitor has run for this edge
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_wr(input int n0, input int budget, input string tag);
    int k = 0;
    while (n_wr == n0 && k < budget) begin tick(); k++; end
    check(tag, n_wr - n0, 1);
  endtask

  task automatic wait_rd(input int n0, input int budget, input string tag);
    int k = 0;
    while (n_rd == n0 && k < budget) begin tick(); k++; end
    check(tag, n_rd - n0, 1);
  endtask

  task automatic wait_oe_rise(input int n0, input int budget, input string tag);
    int k = 0;
    while (n_oe == n0 && k < budget) begin tick(); k++; end
    check(tag, n_oe - n0, 1);
  endtask

  task automatic host_write(input logic [7:0] a, input logic [15:0] d, input logic [1:0] nbl, input int hold);
    int n0;
    @(negedge clk);
    aA = a; aD_in = d; aNBL = nbl; aNE = 1'b0; aNWE = 1'b0;
    exp_q.push_back('{1'b1, a, d, ~nbl});
    n0 = n_wr;
    wait_wr(n0, 10, "wr_strobe");
    tick(hold);
    check("wr_single", n_wr - n0, 1);
    @(negedge clk);
    aNWE = 1'b1; aNE = 1'b1;
    tick(4);
  endtask

  initial begin
    int n0, nw0, nr0, noe0, mark, k;

    nrst = 1'b0; aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1; aNBL = 2'b11;
    aA = '0; aD_in = '0; read_data = '0; err_clr = 1'b0;
    tick(3);
    check("rst_do_write", {31'b0, do_write}, 0);
    check("rst_do_read", {31'b0, do_read}, 0);
    check("rst_oe", {31'b0, aD_oe}, 0);
    check("rst_dout", {16'b0, aD_out}, 0);
    check("rst_adr", {24'b0, rw_adr}, 0);
    check("rst_wbe", {30'b0, w_be}, 0);
    check("rst_err", {31'b0, prot_err}, 0);
`ifdef FSMC_NWAIT_EN
    check("rst_nwait", {31'b0, aNWAIT}, 1);
`endif
    @(negedge clk);
    nrst = 1'b1;
    tick(3);

    // Full-width write: strobe lands 3 clk after the pin edge and never repeats
    @(negedge clk);
    aA = 8'h5A; aD_in = 16'hBEEF; aNBL = 2'b00; aNE = 1'b0; aNWE = 1'b0;
    exp_q.push_back('{1'b1, 8'h5A, 16'hBEEF, 2'b11});
    mark = cyc; n0 = n_wr;
    wait_wr(n0, 10, "wr1_strobe");
    check("wr1_latency", last_wr_cyc - mark, 3);
    tick(20);
    check("wr1_single", n_wr - n0, 1);
    @(negedge clk);
    aNWE = 1'b1; aNE = 1'b1;
    tick(4);

    // Low byte only
    host_write(8'h21, 16'h0034, 2'b10, 3);

    // Read: DRIVE starts RD_LAT cycles after do_read
    @(negedge clk);
    read_data = 16'h1234; aA = 8'h10; aNE = 1'b0; aNOE = 1'b0;
    exp_q.push_back('{1'b0, 8'h10, 16'h0, 2'b00});
    rd_q.push_back(16'h1234);
    n0 = n_rd; noe0 = n_oe; nwait_low = 0;
    wait_rd(n0, 10, "rd1_strobe");
    wait_oe_rise(noe0, RD_LAT + 10, "rd1_oe_rise");
    check("rd1_oe_delay", oe_rise_cyc - last_rd_cyc, RD_LAT);
`ifdef FSMC_NWAIT_EN
    check("rd1_nwait_low_cycles", nwait_low, RD_LAT);
    check("rd1_nwait_high_drive", {31'b0, aNWAIT}, 1);
`endif
    tick(3);
    check("rd1_oe_held", {31'b0, aD_oe}, 1);
    check("rd1_single", n_rd - n0, 1);
    @(negedge clk);
    aNOE = 1'b1;
    mark = cyc; k = 0;
    while (aD_oe && k < 6) begin tick(); k++; end
    // Two synchroniser stages between the pin and the combinational gate
    check("rd1_oe_fall", cyc - mark, 2);
    check("rd1_dout_held", {16'b0, aD_out}, 32'h1234);
    @(negedge clk);
    aNE = 1'b1;
    tick(4);

    // Aborted read: host lets go during RWAIT
    @(negedge clk);
    read_data = 16'hDEAD; aA = 8'h33; aNE = 1'b0; aNOE = 1'b0;
    exp_q.push_back('{1'b0, 8'h33, 16'h0, 2'b00});
    n0 = n_rd; noe0 = n_oe;
    wait_rd(n0, 10, "abort_strobe");
    @(negedge clk);
    aNOE = 1'b1; aNE = 1'b1;
    tick(RD_LAT + 6);
    check("abort_no_oe", n_oe - noe0, 0);
    check("abort_dout_held", {16'b0, aD_out}, 32'h1234);
`ifdef FSMC_NWAIT_EN
    check("abort_nwait", {31'b0, aNWAIT}, 1);
`endif
    host_write(8'h44, 16'hA5A5, 2'b01, 3);

    // Protocol error, then a would-be read while still in HOLD
    nw0 = n_wr; nr0 = n_rd;
    @(negedge clk);
    aNE = 1'b0; aNOE = 1'b0; aNWE = 1'b0;
    tick(5);
    check("err_set", {31'b0, prot_err}, 1);
    @(negedge clk);
    aNWE = 1'b1;
    tick(6);
    check("hold_no_strobe", (n_wr - nw0) + (n_rd - nr0), 0);
    @(negedge clk);
    aNE = 1'b1; aNOE = 1'b1;
    tick(4);
    check("err_sticky", {31'b0, prot_err}, 1);
    @(negedge clk);
    err_clr = 1'b1;
    tick(1);
    check("err_clr", {31'b0, prot_err}, 0);
    @(negedge clk);
    err_clr = 1'b0;

    // err_clr in exactly the cycle the error is detected: set wins
    @(negedge clk);
    aNE = 1'b0; aNOE = 1'b0; aNWE = 1'b0;
    @(negedge clk);
    @(negedge clk);
    err_clr = 1'b1;
    tick(1);
    check("err_set_wins", {31'b0, prot_err}, 1);
    @(negedge clk);
    err_clr = 1'b0; aNE = 1'b1; aNOE = 1'b1; aNWE = 1'b1;
    tick(4);
    check("err_after_set_wins", {31'b0, prot_err}, 1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    tick(1);
    check("err_clr2", {31'b0, prot_err}, 0);

    // Asynchronous reset while driving
    @(negedge clk);
    read_data = 16'hCAFE; aA = 8'h55; aNE = 1'b0; aNOE = 1'b0;
    exp_q.push_back('{1'b0, 8'h55, 16'h0, 2'b00});
    rd_q.push_back(16'hCAFE);
    n0 = n_rd; noe0 = n_oe;
    wait_rd(n0, 10, "rst_rd_strobe");
    wait_oe_rise(noe0, RD_LAT + 10, "rst_rd_oe");
    #1;
    nrst = 1'b0;
    #1;
    check("async_rst_oe", {31'b0, aD_oe}, 0);
    check("async_rst_dout", {16'b0, aD_out}, 0);
    check("async_rst_adr", {24'b0, rw_adr}, 0);
`ifdef FSMC_NWAIT_EN
    check("async_rst_nwait", {31'b0, aNWAIT}, 1);
`endif
    aNE = 1'b1; aNOE = 1'b1;
    tick(3);
    @(negedge clk);
    nrst = 1'b1;
    tick(4);

    // No byte lanes enabled after reset recovery
    host_write(8'h7E, 16'h0F0F, 2'b11, 2);

    tick(2);
    check("exp_q_empty", exp_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
